// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, req/ack instruction-memory port,
// one-entry stall buffer and the IF/ID pipeline register.
module fetch_unit #(
    parameter int unsigned          XLEN     = 32,
    parameter logic [XLEN-1:0]      RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc4,
    output logic [31:0]     if_id_instr
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [XLEN-1:0] buf_pc, buf_pc_next;
    logic [31:0]     buf_word, buf_word_next;
    logic            valid_next;
    logic [XLEN-1:0] id_pc_next, id_pc4_next;
    logic [31:0]     instr_next;
    logic            word_avail;
    logic [XLEN-1:0] word_pc;
    logic [31:0]     word;

    assign imem_req  = (state == FETCH) || (state == DROP);
    assign imem_addr = pc;

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        buf_pc_next   = buf_pc;
        buf_word_next = buf_word;
        valid_next    = if_id_valid;
        id_pc_next    = if_id_pc;
        id_pc4_next   = if_id_pc4;
        instr_next    = if_id_instr;

        word_avail = ((state == FETCH) && imem_ack) || (state == HOLD);
        word       = (state == HOLD) ? buf_word : imem_rdata;
        word_pc    = (state == HOLD) ? buf_pc : pc;

        if (state == IDLE) begin
            // Any ack seen here belongs to a request abandoned by reset.
            state_next = FETCH;
            if (!stall) valid_next = 1'b0;
        end else if (branch_taken) begin
            pc_next       = branch_target & ~(XLEN'(3));
            valid_next    = 1'b0;
            buf_pc_next   = '0;
            buf_word_next = '0;
            if (state == DROP || (state == FETCH && !imem_ack))
                state_next = DROP;
            else
                state_next = FETCH;
        end else if (stall) begin
            if (state == FETCH && imem_ack) begin
                buf_word_next = imem_rdata;
                buf_pc_next   = pc;
                state_next    = HOLD;
            end else if (state == DROP && imem_ack) begin
                state_next = FETCH;
            end
        end else if (word_avail) begin
            valid_next  = 1'b1;
            id_pc_next  = word_pc;
            id_pc4_next = word_pc + XLEN'(4);
            instr_next  = word;
            pc_next     = pc + XLEN'(4);
            state_next  = FETCH;
        end else begin
            valid_next = 1'b0;
            if (state == DROP && imem_ack) state_next = FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            buf_pc      <= '0;
            buf_word    <= '0;
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_pc4   <= '0;
            if_id_instr <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            buf_pc      <= buf_pc_next;
            buf_word    <= buf_word_next;
            if_id_valid <= valid_next;
            if_id_pc    <= id_pc_next;
            if_id_pc4   <= id_pc4_next;
            if_id_instr <= instr_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, every cycle
// compared against a flag-based reference model of the fetch stage.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, branch_taken, stall, imem_ack;
    logic [31:0] branch_target, imem_rdata;
    logic        imem_req, if_id_valid;
    logic [31:0] imem_addr, if_id_pc, if_id_pc4, if_id_instr;

    logic        w_req, w_valid;
    logic [31:0] w_addr, w_pc, w_pc4, w_instr;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // reference model state
    logic        m_started, m_held, m_discard, m_valid;
    logic [31:0] m_pc, m_hpc, m_hword, m_ipc, m_ipc4, m_instr;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .branch_taken(branch_taken), .branch_target(branch_target),
        .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr)
    );

    // Second instance exercises PC wrap-around with an always-ready memory.
    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .branch_taken(1'b0), .branch_target(32'h0),
        .stall(1'b0), .imem_req(w_req), .imem_addr(w_addr), .imem_ack(1'b1),
        .imem_rdata(32'h0000_0013), .if_id_valid(w_valid), .if_id_pc(w_pc),
        .if_id_pc4(w_pc4), .if_id_instr(w_instr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic have;
        if (rst) begin
            m_started = 0; m_held = 0; m_discard = 0; m_pc = 32'h0;
            m_valid = 0; m_ipc = 0; m_ipc4 = 0; m_instr = 0;
        end else if (!m_started) begin
            m_started = 1;
        end else begin
            have = (!m_held && !m_discard && imem_ack) || m_held;
            if (branch_taken) begin
                m_discard = m_discard || (!m_held && !imem_ack);
                m_pc      = {branch_target[31:2], 2'b00};
                m_valid   = 0;
                m_held    = 0;
            end else if (stall) begin
                if (!m_held && !m_discard && imem_ack) begin
                    m_held = 1; m_hword = imem_rdata; m_hpc = m_pc;
                end
                if (m_discard && imem_ack) m_discard = 0;
            end else if (have) begin
                m_valid = 1;
                m_ipc   = m_held ? m_hpc : m_pc;
                m_instr = m_held ? m_hword : imem_rdata;
                m_ipc4  = m_ipc + 32'd4;
                m_pc    = m_pc + 32'd4;
                m_held  = 0;
            end else begin
                m_valid = 0;
                if (m_discard && imem_ack) m_discard = 0;
            end
        end
    endtask

    task automatic step(input logic r, input logic br, input logic [31:0] tgt,
                        input logic st, input logic ak, input logic [31:0] rd);
        rst = r; branch_taken = br; branch_target = tgt;
        stall = st; imem_ack = ak; imem_rdata = rd;
        @(posedge clk);
        model_edge();
        #1;
        check("req",   {31'b0, imem_req}, {31'b0, m_started && !m_held});
        check("addr",  imem_addr, m_pc);
        check("valid", {31'b0, if_id_valid}, {31'b0, m_valid});
        check("pc",    if_id_pc, m_ipc);
        check("pc4",   if_id_pc4, m_ipc4);
        check("instr", if_id_instr, m_instr);
    endtask

    initial begin
        // reset, then IDLE -> FETCH with a stray ack that must be ignored
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 32'h1111_1111);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, if_id_valid}, 32'd0);
        step(0, 0, 0, 0, 1, 32'h2222_2222);
        check("c1_req", {31'b0, imem_req}, 32'd1);
        check("c1_addr", imem_addr, 32'h0);
        check("c1_valid", {31'b0, if_id_valid}, 32'd0);

        // zero-wait stream
        step(0, 0, 0, 0, 1, 32'h0050_0093);
        check("s0_pc", if_id_pc, 32'h0);
        check("s0_instr", if_id_instr, 32'h0050_0093);
        check("wrap_pc", w_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", w_pc4, 32'h0);
        check("wrap_addr", w_addr, 32'h0);
        check("wrap_valid", {31'b0, w_valid}, 32'd1);
        step(0, 0, 0, 0, 1, 32'h00A0_0113);
        check("s1_pc", if_id_pc, 32'h4);
        check("s1_pc4", if_id_pc4, 32'h8);

        // stall while the word at 0x8 arrives
        step(0, 0, 0, 1, 1, 32'h0020_81B3);
        check("hold_req", {31'b0, imem_req}, 32'd0);
        check("hold_pc", if_id_pc, 32'h4);
        step(0, 0, 0, 1, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0);
        check("rel_pc", if_id_pc, 32'h8);
        check("rel_instr", if_id_instr, 32'h0020_81B3);
        check("rel_addr", imem_addr, 32'hC);

        // branch + stall while HOLD holds 0xC
        step(0, 0, 0, 1, 1, 32'hCCCC_CCCC);
        step(0, 1, 32'h100, 1, 0, 32'h0);
        check("bs_valid", {31'b0, if_id_valid}, 32'd0);
        check("bs_addr", imem_addr, 32'h100);
        step(0, 0, 0, 0, 1, 32'h0000_0100);
        check("bs_pc", if_id_pc, 32'h100);

        // redirect mid-request, late data discarded
        step(0, 0, 0, 0, 0, 32'h0);
        step(0, 1, 32'h103, 0, 0, 32'h0);
        check("drop_addr", imem_addr, 32'h100);
        step(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        check("drop_valid", {31'b0, if_id_valid}, 32'd0);
        check("drop_addr2", imem_addr, 32'h100);
        step(0, 0, 0, 0, 1, 32'h0000_0AAA);
        check("after_drop_pc", if_id_pc, 32'h100);
        check("after_drop_instr", if_id_instr, 32'h0000_0AAA);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 7) == 0),
                 $urandom,
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 0),
                 $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
